// File: rtl/ex_cpuid_pkg.sv
// ---------------------------------------------------------------------------
// ex_cpuid_pkg
// Shared definitions for the CPUID/RNG query sequencer: the sequencer state
// encoding and the CPUID index constants (index width, RNG leaf number).
// ---------------------------------------------------------------------------
package ex_cpuid_pkg;

    localparam int CPUID_IDX_W = 5;

    // Leaf 31 reads the RNG shift register; it needs refresh spacing.
    localparam logic [CPUID_IDX_W-1:0] CPUID_IDX_RNG = 5'h1F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } schedState_t;

endpackage

// File: rtl/ex_rr_arb.sv
// ---------------------------------------------------------------------------
// ex_rr_arb
// Purely combinational round-robin picker. Grants the first set bit of
// reqMask found when scanning upward from rrPtr, wrapping past NREQ-1.
//
// Ports:
//   reqMask  in   NREQ    candidate requesters
//   rrPtr    in   PTR_W   highest-priority position for this pick
//   grant    out  NREQ    one-hot grant, zero when reqMask is empty
// ---------------------------------------------------------------------------
module ex_rr_arb #(
    parameter  int NREQ  = 2,
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  reqMask,
    input  logic [PTR_W-1:0] rrPtr,
    output logic [NREQ-1:0]  grant
);

    always_comb begin
        logic             found;
        int               pos;
        logic [PTR_W-1:0] sel;
        grant = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Position k steps after the pointer, modulo NREQ (NREQ need
            // not be a power of two, so no free wrap from the bit width).
            pos = int'(rrPtr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            sel = PTR_W'(pos);
            if (!found && reqMask[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_cpuid_sched.sv
// ---------------------------------------------------------------------------
// ex_cpuid_sched
// Shares the single CPUID/RNG query unit among NREQ requesters. Requests are
// arbitrated round-robin, the winner's index is registered onto cpuIndex,
// the unit's 128-bit result is captured one clock later and handed back with
// a valid/ready handshake. Reads of the RNG leaf (index 31) are held off
// until RNG_GAP clocks have passed since the previous RNG capture, so each
// result is built from fully refreshed shift-register bits.
//
// Ports:
//   clock     in   1        system clock
//   reset     in   1        asynchronous, active-high reset
//   reqValid  in   NREQ     per-requester query request
//   reqIndex  in   5*NREQ   per-requester CPUID index, slice i = [5i+4:5i]
//   reqReady  out  NREQ     one-hot grant (accept = reqValid & reqReady)
//   rspValid  out  NREQ     one-hot response valid for the query owner
//   rspReady  in   NREQ     per-requester response acceptance
//   rspLo     out  64       captured result, low half
//   rspHi     out  64       captured result, high half
//   cpuIndex  out  5        registered index to the CPUID unit
//   cpuResLo  in   64       CPUID unit result, low (combinational on cpuIndex)
//   cpuResHi  in   64       CPUID unit result, high
//   busy      out  1        a query is in flight (not IDLE)
// ---------------------------------------------------------------------------
module ex_cpuid_sched
    import ex_cpuid_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int RNG_GAP = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0]             reqValid,
    input  logic [CPUID_IDX_W*NREQ-1:0] reqIndex,
    output logic [NREQ-1:0]             reqReady,
    output logic [NREQ-1:0]             rspValid,
    input  logic [NREQ-1:0]             rspReady,
    output logic [63:0]                 rspLo,
    output logic [63:0]                 rspHi,
    output logic [CPUID_IDX_W-1:0]      cpuIndex,
    input  logic [63:0]                 cpuResLo,
    input  logic [63:0]                 cpuResHi,
    output logic                        busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(RNG_GAP + 1);

    schedState_t            state;
    logic [PTR_W-1:0]       rrPtr;
    logic [PTR_W-1:0]       owner;
    logic [CNT_W-1:0]       rngCnt;
    logic                   rngReady;
    logic [NREQ-1:0]        eligible;
    logic [NREQ-1:0]        grant;
    logic [PTR_W-1:0]       grantIdx;
    logic [CPUID_IDX_W-1:0] selIndex;
    logic [PTR_W-1:0]       nextPtr;

    assign rngReady = (rngCnt == CNT_W'(RNG_GAP));

    // A pending RNG read that is still inside its refresh gap is simply
    // masked out, so it never blocks the other requesters.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = reqValid[i] &&
                          ((reqIndex[CPUID_IDX_W*i +: CPUID_IDX_W] != CPUID_IDX_RNG) || rngReady);
        end
    end

    ex_rr_arb #(
        .NREQ (NREQ)
    ) uArb (
        .reqMask (eligible),
        .rrPtr   (rrPtr),
        .grant   (grant)
    );

    always_comb begin
        selIndex = '0;
        grantIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                selIndex = reqIndex[CPUID_IDX_W*i +: CPUID_IDX_W];
                grantIdx = PTR_W'(i);
            end
        end
    end

    // The grant is only offered while idle; gating with reset keeps it low
    // during reset even though the arbiter itself is combinational.
    assign reqReady = (state == IDLE && !reset) ? grant : '0;

    assign nextPtr = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rrPtr    <= '0;
            owner    <= '0;
            cpuIndex <= '0;
            rspLo    <= '0;
            rspHi    <= '0;
            rspValid <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                // IDLE -> ISSUE: latch the winner and its index
                IDLE: begin
                    if (|grant) begin
                        owner    <= grantIdx;
                        cpuIndex <= selIndex;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                // ISSUE -> RESP: cpuIndex has been stable a full clock
                ISSUE: begin
                    rspLo    <= cpuResLo;
                    rspHi    <= cpuResHi;
                    rspValid <= NREQ'(1) << owner;
                    state    <= RESP;
                end
                // RESP -> IDLE: only the owner's rspReady counts
                RESP: begin
                    if (rspReady[owner]) begin
                        rspValid <= '0;
                        busy     <= 1'b0;
                        rrPtr    <= nextPtr;
                        state    <= IDLE;
                    end
                end
                default: begin
                    rspValid <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Clocks since the last RNG capture, saturating at RNG_GAP. The clear
    // lands on the capture edge itself and wins over the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rngCnt <= '0;
        end else if (state == ISSUE && cpuIndex == CPUID_IDX_RNG) begin
            rngCnt <= '0;
        end else if (!rngReady) begin
            rngCnt <= rngCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_cpuid_sched.sv
module tb_ex_cpuid_sched;

    localparam int NREQ    = 3;
    localparam int RNG_GAP = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   reqValid = '0;
    logic [5*NREQ-1:0] reqIndex = '0;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ-1:0]   rspValid;
    logic [NREQ-1:0]   rspReady = '0;
    logic [63:0]       rspLo, rspHi, cpuResLo, cpuResHi;
    logic [4:0]        cpuIndex;
    logic              busy;

    logic [31:0] rngShift = 32'h1234_5678;
    int          cyc;
    int          nCmp = 0;
    int          nBad = 0;

    ex_cpuid_sched #(.NREQ(NREQ), .RNG_GAP(RNG_GAP)) dut (
        .clock    (clock),
        .reset    (reset),
        .reqValid (reqValid),
        .reqIndex (reqIndex),
        .reqReady (reqReady),
        .rspValid (rspValid),
        .rspReady (rspReady),
        .rspLo    (rspLo),
        .rspHi    (rspHi),
        .cpuIndex (cpuIndex),
        .cpuResLo (cpuResLo),
        .cpuResHi (cpuResHi),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // CPUID unit stand-in: leaf 0 is the vendor string, leaf 31 the RNG
    // shift register (changes every clock), other leaves a fixed pattern.
    function automatic logic [127:0] cpuModel(input logic [4:0] idx, input logic [31:0] rng);
        if (idx == 5'd0)  return {64'h0, 64'h2020324632584A42};
        if (idx == 5'd31) return {32'h0, ~rng, 32'h0, rng};
        return {8'hA0, 51'h0, idx, 32'h1234_0000, 27'h0, idx};
    endfunction

    assign {cpuResHi, cpuResLo} = cpuModel(cpuIndex, rngShift);

    always @(posedge clock)
        rngShift <= {rngShift[30:0], 1'b0} ^ (rngShift[31] ? 32'h0040_0007 : 32'h0);

    // Clocks elapsed since reset release (0 until the first edge after it).
    always @(posedge clock or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] want);
        nCmp++;
        if (obs !== want) begin
            nBad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    // Requester side: a pending request holds its index until accepted.
    bit              pend [NREQ];
    logic [4:0]      pIdx [NREQ];
    logic [NREQ-1:0] enMask;
    int              newPct, rngPct, readyPct;

    // Reference model of the sequencer, in transaction terms.
    int           phase;      // 0 waiting for a grant, 1 query issued, 2 response offered
    int           mPtr, mOwner;
    logic [4:0]   mIdx;
    logic [127:0] mData;
    int           rngRef;     // cycle from which the RNG refresh gap is counted
    logic [63:0]  prevRng;
    bit           haveRng;

    // Accepts as observed on the DUT ports.
    int dutLog[$];
    int dutCycLog[$];
    int dutGrantCyc [NREQ];

    task automatic modelInit();
        phase = 0; mPtr = 0; mOwner = 0; mIdx = 5'd0; mData = '0; rngRef = 0; haveRng = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; pIdx[i] = 5'd0; dutGrantCyc[i] = -1;
        end
        dutLog.delete();
        dutCycLog.delete();
    endtask

    task automatic step();
        int              win;
        int              j;
        logic [NREQ-1:0] wantGrant, wantRsp, acc;
        @(negedge clock);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && enMask[i] && $urandom_range(99) < newPct) begin
                pend[i] = 1;
                pIdx[i] = ($urandom_range(99) < rngPct) ? 5'd31 : 5'($urandom_range(30));
            end
            reqValid[i]       = pend[i];
            reqIndex[5*i +: 5] = pend[i] ? pIdx[i] : 5'($urandom);
            rspReady[i]       = ($urandom_range(99) < readyPct);
        end
        #1;
        acc = reqValid & reqReady;
        for (int i = 0; i < NREQ; i++)
            if (acc[i]) begin
                dutLog.push_back(i);
                dutCycLog.push_back(cyc);
                dutGrantCyc[i] = cyc;
            end

        win = -1;
        wantGrant = '0;
        wantRsp = '0;
        if (phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (mPtr + k) % NREQ;
                if (win < 0 && pend[j] && (pIdx[j] != 5'd31 || cyc - rngRef >= RNG_GAP)) win = j;
            end
            if (win >= 0) wantGrant[win] = 1'b1;
        end
        if (phase == 2) wantRsp[mOwner] = 1'b1;

        checkVal("reqReady", reqReady, wantGrant);
        checkVal("rspValid", rspValid, wantRsp);
        checkVal("busy", busy, phase != 0);
        checkVal("cpuIndex", cpuIndex, mIdx);
        if (phase == 2) checkVal("rspData", {rspHi, rspLo}, mData);

        case (phase)
            0: if (win >= 0) begin
                mOwner = win; mIdx = pIdx[win]; pend[win] = 0; phase = 1;
            end
            1: begin
                mData = cpuModel(mIdx, rngShift);
                if (mIdx == 5'd31) rngRef = cyc + 1;
                phase = 2;
            end
            default: if (rspReady[mOwner]) begin
                if (mIdx == 5'd31) begin
                    if (haveRng) checkVal("rngFresh", rspLo != prevRng, 1);
                    prevRng = rspLo;
                    haveRng = 1;
                end
                mPtr = (mOwner + 1) % NREQ;
                phase = 0;
            end
        endcase
    endtask

    // Asserts reset mid-cycle (optionally checking outputs fall at once),
    // holds it for two edges and releases it just after a falling edge.
    task automatic applyReset(input bit checkOutputs);
        @(negedge clock);
        #2;
        reqValid = '1;
        reset = 1'b1;
        #1;
        if (checkOutputs) begin
            checkVal("rstReqReady", reqReady, 0);
            checkVal("rstRspValid", rspValid, 0);
            checkVal("rstBusy", busy, 0);
            checkVal("rstCpuIndex", cpuIndex, 0);
            checkVal("rstRspData", {rspHi, rspLo}, 0);
        end
        repeat (2) @(posedge clock);
        #1;
        if (checkOutputs) checkVal("rstHoldReqReady", reqReady, 0);
        @(negedge clock);
        reset = 1'b0;
        reqValid = '0;
        rspReady = '0;
        modelInit();
    endtask

    task automatic runSteps(input int n);
        for (int n2 = 0; n2 < n; n2++) step();
    endtask

    initial begin
        bit reraised;
        modelInit();
        enMask = '0; newPct = 0; rngPct = 0; readyPct = 100;

        // Reset state with all requesters asking.
        applyReset(1);

        // Single query of leaf 0.
        pend[0] = 1; pIdx[0] = 5'd0;
        runSteps(5);
        checkVal("singleCount", dutLog.size(), 1);

        // Two requesters from reset; requester 0 asks again right after its grant.
        applyReset(0);
        pend[0] = 1; pIdx[0] = 5'd1;
        pend[1] = 1; pIdx[1] = 5'd2;
        reraised = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (dutLog.size() == 1 && !reraised) begin
                pend[0] = 1; pIdx[0] = 5'd1; reraised = 1;
            end
        end
        checkVal("rrCount", dutLog.size(), 3);
        if (dutLog.size() == 3) begin
            checkVal("rrFirst", dutLog[0], 0);
            checkVal("rrSecond", dutLog[1], 1);
            checkVal("rrThird", dutLog[2], 0);
        end

        // RNG request at cycle 5 alongside an ordinary one.
        applyReset(0);
        for (int n = 0; n < 10 && cyc < 4; n++) step();
        pend[0] = 1; pIdx[0] = 5'd31;
        pend[1] = 1; pIdx[1] = 5'd1;
        runSteps(40);
        checkVal("rngBypassCount", dutLog.size(), 2);
        if (dutLog.size() == 2) begin
            checkVal("rngBypassFirst", dutLog[0], 1);
            checkVal("rngBypassSecond", dutLog[1], 0);
        end
        checkVal("rngFirstGrant", dutGrantCyc[0], RNG_GAP);

        // Back-to-back RNG reads from one requester.
        applyReset(0);
        enMask = 3'b001; newPct = 100; rngPct = 100; readyPct = 100;
        runSteps(150);
        checkVal("rngB2bCount", dutLog.size(), 4);
        for (int k = 1; k < dutCycLog.size(); k++)
            checkVal("rngSpacing", dutCycLog[k] - dutCycLog[k-1] >= RNG_GAP + 1, 1);
        enMask = '0; newPct = 0; rngPct = 0;
        runSteps(4);

        // Response stall with another requester waiting.
        readyPct = 0;
        pend[1] = 1; pIdx[1] = 5'd5;
        pend[0] = 1; pIdx[0] = 5'd7;
        runSteps(14);
        readyPct = 100;
        runSteps(6);
        checkVal("stallPending", pend[0] || pend[1], 0);

        // Reset while a response is stalled.
        applyReset(0);
        pend[0] = 1; pIdx[0] = 5'd2;
        runSteps(4);
        readyPct = 0;
        pend[0] = 1; pIdx[0] = 5'd3;
        runSteps(4);
        checkVal("midRespValid", rspValid, 3'b001);
        applyReset(1);
        readyPct = 100;
        pend[0] = 1; pIdx[0] = 5'd4;
        pend[1] = 1; pIdx[1] = 5'd6;
        runSteps(3);
        checkVal("postResetCount", dutLog.size(), 1);
        if (dutLog.size() >= 1) checkVal("postResetWinner", dutLog[0], 0);

        // Randomized traffic.
        applyReset(0);
        enMask = '1; newPct = 35; rngPct = 20; readyPct = 70;
        runSteps(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
